egress_collector: RTL and testbench

Downstream stage of the transmission-layer datapath: drains the two destination FIFOs (D0, D1) and merges them into a single registered 6-bit output stream with a valid/ready handshake. Pop requests are driven back into the destination FIFOs. Draining is enabled only while the link state machine reports active. Arbitration between D0 and D1 is round-robin, so neither destination starves.

---
 rtl/egress_collector.sv | 129 ++++++++++++
 tb/tb_egress_collector.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/egress_collector.sv
// egress_collector: drains destination FIFOs D0/D1 with a round-robin
// grant and merges them into one registered valid/ready output stream.
// Each word takes IDLE (pop) -> FETCH (capture) -> HOLD (handshake).
// Optional feature macro: EGRESS_COUNT_EN adds the per-destination
// delivered-word counters; without it count_D0/count_D1 are tied to 0.
module egress_collector #(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  active_in,
  input  logic [DATA_WIDTH-1:0] data_out_D0,
  input  logic [DATA_WIDTH-1:0] data_out_D1,
  input  logic                  empty_fifo_D0,
  input  logic                  empty_fifo_D1,
  input  logic                  out_ready,
  output logic                  D0_pop,
  output logic                  D1_pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  src_out,
  output logic [CNT_WIDTH-1:0]  count_D0,
  output logic [CNT_WIDTH-1:0]  count_D1
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  sel_q, sel_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  src_q, src_d;

  logic eligible;
  logic grant;

  // A pop may only be decided while the link is up and something is queued.
  assign eligible = active_in && !(empty_fifo_D0 && empty_fifo_D1);
  // With both queues occupied the source opposite the previous grant wins;
  // otherwise the only non-empty source wins (empty D0 implies D1).
  assign grant = (!empty_fifo_D0 && !empty_fifo_D1) ? !last_grant_q : empty_fifo_D0;

  // Next-state and pop decode; pops are held low during reset so nothing
  // is drained from the FIFOs while the block is being cleared.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    data_d       = data_q;
    valid_d      = valid_q;
    src_d        = src_q;
    D0_pop       = 1'b0;
    D1_pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (eligible && !reset) begin
          D0_pop       = !grant;
          D1_pop       = grant;
          last_grant_d = grant;
          sel_d        = grant;
          state_d      = FETCH;
        end
      end
      FETCH: begin
        data_d  = sel_q ? data_out_D1 : data_out_D0;
        src_d   = sel_q;
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      sel_q        <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      src_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      src_q        <= src_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign src_out   = src_q;

`ifdef EGRESS_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt0_q, cnt1_q;
  logic                 xfer;

  assign xfer = (state_q == HOLD) && out_ready;

  // Count completed handshakes per source, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (xfer) begin
      if (!src_q && (cnt0_q != '1)) cnt0_q <= cnt0_q + 1'b1;
      if (src_q && (cnt1_q != '1))  cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign count_D0 = cnt0_q;
  assign count_D1 = cnt1_q;
`else
  assign count_D0 = '0;
  assign count_D1 = '0;
`endif

endmodule

// File: tb/tb_egress_collector.sv
// Bench for egress_collector: behavioural FIFO models feed the DUT, a
// transaction-level round-robin plan predicts the output order, and a
// negedge monitor checks handshake, latency, pop legality and counters.
module tb_egress_collector;

`ifdef EGRESS_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       active_in = 1'b0;
  logic [5:0] data_out_D0 = '0;
  logic [5:0] data_out_D1 = '0;
  logic       empty_fifo_D0 = 1'b1;
  logic       empty_fifo_D1 = 1'b1;
  logic       out_ready = 1'b0;
  logic       D0_pop, D1_pop;
  logic [5:0] data_out;
  logic       valid_out, src_out;
  logic [7:0] count_D0, count_D1;

  egress_collector dut (
    .clk(clk), .reset(reset), .active_in(active_in),
    .data_out_D0(data_out_D0), .data_out_D1(data_out_D1),
    .empty_fifo_D0(empty_fifo_D0), .empty_fifo_D1(empty_fifo_D1),
    .out_ready(out_ready), .D0_pop(D0_pop), .D1_pop(D1_pop),
    .data_out(data_out), .valid_out(valid_out), .src_out(src_out),
    .count_D0(count_D0), .count_D1(count_D1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Destination FIFO models: read data appears the cycle after a pop.
  logic [5:0] q0[$];
  logic [5:0] q1[$];
  int n_pops = 0;
  int n_pop1 = 0;

  always @(posedge clk) begin
    if (D0_pop && q0.size() > 0) begin
      data_out_D0 <= q0.pop_front();
      n_pops++;
    end
    if (D1_pop && q1.size() > 0) begin
      data_out_D1 <= q1.pop_front();
      n_pops++;
      n_pop1++;
    end
    empty_fifo_D0 <= (q0.size() == 0);
    empty_fifo_D1 <= (q1.size() == 0);
  end

  // Reference: expected {src,data} sequence and delivered-word counts.
  logic [6:0] exp_q[$];
  logic [5:0] got_q[$];
  int         xfer_cyc[$];
  logic       ref_last = 1'b1;
  int         m_cnt0 = 0;
  int         m_cnt1 = 0;

  // Round-robin drain order of the current FIFO contents (no further pushes).
  task automatic plan();
    int   i0 = 0;
    int   i1 = 0;
    logic s;
    while (i0 < q0.size() || i1 < q1.size()) begin
      if (i0 < q0.size() && i1 < q1.size()) s = !ref_last;
      else s = (i1 < q1.size());
      if (s) begin exp_q.push_back({1'b1, q1[i1]}); i1++; end
      else   begin exp_q.push_back({1'b0, q0[i0]}); i0++; end
      ref_last = s;
    end
  endtask

  // Monitor, sampled on the falling edge.
  int   cyc = 0;
  int   pop_cyc = -10;
  logic inflight = 1'b0;
  logic was_reset = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      check_eq("rst_pops", {D0_pop, D1_pop}, 0);
      inflight  = 1'b0;
      was_reset = 1'b1;
      m_cnt0    = 0;
      m_cnt1    = 0;
    end else begin
      if (was_reset) begin
        check_eq("rst_valid", valid_out, 0);
        check_eq("rst_data", data_out, 0);
        check_eq("rst_src", src_out, 0);
        was_reset = 1'b0;
      end
      check_eq("count_D0", count_D0, CNT_ON ? m_cnt0 : 0);
      check_eq("count_D1", count_D1, CNT_ON ? m_cnt1 : 0);
      check_eq("pop_excl", D0_pop & D1_pop, 0);
      if (D0_pop || D1_pop) begin
        check_eq("pop_inflight", inflight, 0);
        check_eq("pop_active", active_in, 1);
        if (D0_pop) check_eq("pop_d0_empty", empty_fifo_D0, 0);
        if (D1_pop) check_eq("pop_d1_empty", empty_fifo_D1, 0);
        if (exp_q.size() == 0) check_eq("pop_unexpected", 1, 0);
        else check_eq("pop_src", D1_pop, exp_q[0][6]);
        inflight = 1'b1;
        pop_cyc  = cyc;
      end
      if (inflight && cyc == pop_cyc + 1) check_eq("fetch_valid", valid_out, 0);
      if (inflight && cyc == pop_cyc + 2) check_eq("lat_valid", valid_out, 1);
      if (valid_out) begin
        if (exp_q.size() == 0) check_eq("valid_unexpected", 1, 0);
        else begin
          check_eq("data_out", data_out, exp_q[0][5:0]);
          check_eq("src_out", src_out, exp_q[0][6]);
          if (out_ready) begin
            if (exp_q[0][6]) begin if (m_cnt1 < 255) m_cnt1++; end
            else begin if (m_cnt0 < 255) m_cnt0++; end
            got_q.push_back(exp_q[0][5:0]);
            xfer_cyc.push_back(cyc);
            void'(exp_q.pop_front());
            inflight = 1'b0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run until every planned word is delivered, bounded by max_cyc.
  task automatic drain(input int max_cyc, input bit rnd_ready);
    for (int i = 0; i < max_cyc; i++) begin
      if (exp_q.size() == 0 && !inflight) break;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
    end
    check_eq("drain_done", (exp_q.size() == 0 && !inflight), 1);
    out_ready = 1'b0;
  endtask

  task automatic wait_pop(input int p0);
    for (int i = 0; i < 20 && n_pops == p0; i++) step();
    check_eq("saw_pop", n_pops - p0, 1);
  endtask

  initial begin
    int p0;
    int n0;
    int n1;
    // Reset sequencing with both FIFOs loaded, then round-robin order.
    q0.push_back(6'h01); q0.push_back(6'h02);
    q1.push_back(6'h31); q1.push_back(6'h32);
    plan();
    step(); step();
    reset = 1'b0; active_in = 1'b1;
    @(negedge clk); #1;
    check_eq("first_pop_d0", D0_pop, 1);
    got_q.delete();
    drain(60, 1'b0);
    check_eq("rr_len", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check_eq("rr_w0", got_q[0], 6'h01);
      check_eq("rr_w1", got_q[1], 6'h31);
      check_eq("rr_w2", got_q[2], 6'h02);
      check_eq("rr_w3", got_q[3], 6'h32);
    end

    // Single source, out_ready held high: words 3 cycles apart, no D1 pop.
    active_in = 1'b0;
    q0.push_back(6'h05); q0.push_back(6'h2A);
    step(); step();
    plan();
    p0 = n_pop1;
    active_in = 1'b1;
    drain(60, 1'b0);
    check_eq("single_no_d1", n_pop1 - p0, 0);
    if (xfer_cyc.size() >= 2)
      check_eq("single_spacing", xfer_cyc[$] - xfer_cyc[$-1], 3);

    // Inactive link with both FIFOs loaded: nothing popped.
    active_in = 1'b0;
    q0.push_back(6'h0A); q0.push_back(6'h0B);
    q1.push_back(6'h1C);
    p0 = n_pops;
    repeat (6) step();
    check_eq("inactive_no_pop", n_pops - p0, 0);

    // Backpressure: hold 5 cycles, accept once, IDLE pops the next cycle.
    plan();
    active_in = 1'b1;
    for (int i = 0; i < 20 && !valid_out; i++) step();
    check_eq("bp_valid", valid_out, 1);
    p0 = n_pops;
    repeat (5) step();
    check_eq("bp_no_pop", n_pops - p0, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge clk); #1;
    check_eq("bp_idle_pop", D0_pop | D1_pop, 1);
    drain(60, 1'b0);

    // Link drops during FETCH: word still delivered, no further pop.
    active_in = 1'b0;
    q0.push_back(6'h11); q0.push_back(6'h12);
    step(); step();
    plan();
    p0 = n_pops;
    active_in = 1'b1; out_ready = 1'b1;
    wait_pop(p0);
    active_in = 1'b0;
    got_q.delete();
    repeat (10) step();
    check_eq("drop_pops", n_pops - p0, 1);
    check_eq("drop_delivered", got_q.size(), 1);
    check_eq("drop_left", exp_q.size(), 1);
    active_in = 1'b1;
    drain(60, 1'b0);

    // Reset while in FETCH: popped word is discarded.
    active_in = 1'b0;
    q0.push_back(6'h21); q1.push_back(6'h22);
    step(); step();
    plan();
    p0 = n_pops;
    active_in = 1'b1; out_ready = 1'b1;
    wait_pop(p0);
    reset = 1'b1;
    step();
    exp_q.delete();
    ref_last = 1'b1;
    plan();
    step();
    reset = 1'b0;
    drain(60, 1'b0);

    // Randomized phases: load with link down, then drain with random ready.
    for (int ph = 0; ph < 15; ph++) begin
      active_in = 1'b0;
      n0 = $urandom_range(0, 6);
      n1 = $urandom_range(0, 6);
      for (int k = 0; k < n0; k++) q0.push_back(6'($urandom));
      for (int k = 0; k < n1; k++) q1.push_back(6'($urandom));
      step(); step();
      plan();
      active_in = 1'b1;
      drain(400, 1'b1);
    end

    // Counter saturation on D1.
    active_in = 1'b0;
    for (int k = 0; k < 260; k++) q1.push_back(6'($urandom));
    step(); step();
    plan();
    active_in = 1'b1;
    drain(1000, 1'b0);
    step();
    @(negedge clk); #1;
    check_eq("sat_count_D1", count_D1, CNT_ON ? 255 : 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
